cv32e40p_compressed_dec_ft: RTL and testbench

// - Fault-tolerant (TMR) RVC decompressor for the cv32e40p IF stage.
// - Three replicas of the RVC->RV32 decoder, one per redundant lane.
// - All outputs are majority-voted over the healthy replicas.
// - Per-replica error tracking declares a replica broken; broken replicas are excluded from voting.

---
 rtl/cv32e40p_ft_pkg.sv | 25 ++
 rtl/cv32e40p_compressed_decoder.sv | 119 +++++++++++
 rtl/cv32e40p_compressed_dec_ft.sv | 120 ++++++++++++
 tb/tb_cv32e40p_compressed_dec_ft.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// Shared definitions for the TMR RVC decompressor: replica count, default
// error-tracking parameters, RV32 opcodes and the per-replica decode bundle.
package cv32e40p_ft_pkg;

    localparam int unsigned N_REP          = 3;
    localparam int unsigned ERR_THRESH_DEF = 8;
    localparam int unsigned CNT_W_DEF      = 8;

    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_JAL    = 7'h6f;

    // One replica's complete decode result; compared as a whole by the voter.
    typedef struct packed {
        logic        illegal;
        logic        is_compressed;
        logic [31:0] instr;
    } dec_bundle_t;

endpackage

// File: rtl/cv32e40p_compressed_decoder.sv
// Single-lane RVC -> RV32 decompressor (no FPU: compressed FP loads/stores
// decode as illegal). Purely combinational.
module cv32e40p_compressed_decoder
    import cv32e40p_ft_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_o,
    output logic        illegal_instr_o
);

    // Expand the 16-bit encoding by quadrant / funct3; 32-bit words pass through.
    always_comb begin
        illegal_instr_o = 1'b0;
        instr_o         = '0;
        case (instr_i[1:0])
            2'b00: begin
                case (instr_i[15:13])
                    3'b000: begin // c.addi4spn
                        instr_o = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                                   5'h02, 3'b000, 2'b01, instr_i[4:2], OPCODE_OPIMM};
                        if (instr_i[12:5] == 8'b0) illegal_instr_o = 1'b1;
                    end
                    3'b010: // c.lw
                        instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01, instr_i[9:7],
                                   3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD};
                    3'b110: // c.sw
                        instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                   3'b010, instr_i[11:10], instr_i[6], 2'b00, OPCODE_STORE};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            2'b01: begin
                case (instr_i[15:13])
                    3'b000: // c.addi / c.nop
                        instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b0,
                                   instr_i[11:7], OPCODE_OPIMM};
                    3'b001, 3'b101: // c.jal / c.j
                        instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7], instr_i[2],
                                   instr_i[11], instr_i[5:3], {9{instr_i[12]}}, 4'b0, ~instr_i[15], OPCODE_JAL};
                    3'b010: // c.li
                        instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0, 3'b0,
                                   instr_i[11:7], OPCODE_OPIMM};
                    3'b011: begin // c.addi16sp / c.lui
                        if (instr_i[11:7] == 5'h02)
                            instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0,
                                       5'h02, 3'b000, 5'h02, OPCODE_OPIMM};
                        else
                            instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPCODE_LUI};
                        if ({instr_i[12], instr_i[6:2]} == 6'b0) illegal_instr_o = 1'b1;
                    end
                    3'b100: begin
                        case (instr_i[11:10])
                            2'b00, 2'b01: begin // c.srli / c.srai
                                instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7],
                                           3'b101, 2'b01, instr_i[9:7], OPCODE_OPIMM};
                                if (instr_i[12]) illegal_instr_o = 1'b1;
                            end
                            2'b10: // c.andi
                                instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7],
                                           3'b111, 2'b01, instr_i[9:7], OPCODE_OPIMM};
                            default: begin
                                case ({instr_i[12], instr_i[6:5]})
                                    3'b000: instr_o = {2'b01, 5'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b000, 2'b01, instr_i[9:7], OPCODE_OP}; // c.sub
                                    3'b001: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b100, 2'b01, instr_i[9:7], OPCODE_OP}; // c.xor
                                    3'b010: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b110, 2'b01, instr_i[9:7], OPCODE_OP}; // c.or
                                    3'b011: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                                       3'b111, 2'b01, instr_i[9:7], OPCODE_OP}; // c.and
                                    default: illegal_instr_o = 1'b1;
                                endcase
                            end
                        endcase
                    end
                    default: // c.beqz / c.bnez
                        instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, instr_i[9:7],
                                   2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12], OPCODE_BRANCH};
                endcase
            end
            2'b10: begin
                case (instr_i[15:13])
                    3'b000: begin // c.slli
                        instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPCODE_OPIMM};
                        if (instr_i[12]) illegal_instr_o = 1'b1;
                    end
                    3'b010: begin // c.lwsp
                        instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                                   instr_i[11:7], OPCODE_LOAD};
                        if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
                    end
                    3'b100: begin
                        if (!instr_i[12]) begin
                            if (instr_i[6:2] == 5'b0) begin // c.jr
                                instr_o = {12'b0, instr_i[11:7], 3'b0, 5'b0, OPCODE_JALR};
                                if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
                            end else // c.mv
                                instr_o = {7'b0, instr_i[6:2], 5'b0, 3'b0, instr_i[11:7], OPCODE_OP};
                        end else if (instr_i[6:2] != 5'b0) // c.add
                            instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b0, instr_i[11:7], OPCODE_OP};
                        else if (instr_i[11:7] == 5'b0) // c.ebreak
                            instr_o = 32'h0010_0073;
                        else // c.jalr
                            instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b00001, OPCODE_JALR};
                    end
                    3'b110: // c.swsp
                        instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                                   instr_i[11:9], 2'b00, OPCODE_STORE};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            default: instr_o = instr_i;
        endcase
    end

    assign is_compressed_o = (instr_i[1:0] != 2'b11);

endmodule

// File: rtl/cv32e40p_compressed_dec_ft.sv
// TMR RVC decompressor: three decoder replicas, a voter over the healthy
// replicas and per-replica broken flags. With CV32E40P_FT_AUTO_BROKEN_EN
// defined, leaky error counters declare a replica broken automatically;
// otherwise only set_broken_i can break a replica.
module cv32e40p_compressed_dec_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned ERR_THRESH = ERR_THRESH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REP-1:0][31:0] instr_i,
    output logic [N_REP-1:0][31:0] instr_o,
    output logic [N_REP-1:0]       is_compressed_o,
    output logic [N_REP-1:0]       illegal_instr_o,
    input  logic [N_REP-1:0]       set_broken_i,
    output logic [N_REP-1:0]       is_broken_o
);

    logic [N_REP-1:0][31:0] dec_instr;
    logic [N_REP-1:0]       dec_comp;
    logic [N_REP-1:0]       dec_ill;
    dec_bundle_t [N_REP-1:0] bundle;
    dec_bundle_t            voted;
    logic                   split;
    logic [N_REP-1:0]       healthy;
    logic [N_REP-1:0]       mismatch;
    logic [N_REP-1:0]       is_broken_q, is_broken_d;

    for (genvar k = 0; k < N_REP; k++) begin : g_rep
        cv32e40p_compressed_decoder u_dec (
            .instr_i         (instr_i[k]),
            .instr_o         (dec_instr[k]),
            .is_compressed_o (dec_comp[k]),
            .illegal_instr_o (dec_ill[k])
        );
    end

    // Pack each replica's result into one comparable bundle.
    always_comb begin
        for (int k = 0; k < N_REP; k++)
            bundle[k] = '{illegal: dec_ill[k], is_compressed: dec_comp[k], instr: dec_instr[k]};
    end

    assign healthy = ~is_broken_q;

    // Vote over healthy replicas. With two healthy the lower index wins either
    // way; split flags a disagreement so both survivors get charged.
    always_comb begin
        voted = bundle[0];
        split = 1'b0;
        case (healthy)
            3'b111: voted = (bundle[0] & bundle[1]) | (bundle[0] & bundle[2]) | (bundle[1] & bundle[2]);
            3'b011: begin voted = bundle[0]; split = (bundle[0] != bundle[1]); end
            3'b101: begin voted = bundle[0]; split = (bundle[0] != bundle[2]); end
            3'b110: begin voted = bundle[1]; split = (bundle[1] != bundle[2]); end
            3'b010: voted = bundle[1];
            3'b100: voted = bundle[2];
            default: voted = bundle[0];
        endcase
    end

    // Replicate the voted result onto every lane and flag disagreeing replicas.
    always_comb begin
        for (int k = 0; k < N_REP; k++) begin
            instr_o[k]         = voted.instr;
            is_compressed_o[k] = voted.is_compressed;
            illegal_instr_o[k] = voted.illegal;
            mismatch[k]        = healthy[k] & ((bundle[k] != voted) | split);
        end
    end

`ifdef CV32E40P_FT_AUTO_BROKEN_EN
    logic [N_REP-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Leaky counters: up on mismatch, down otherwise; frozen once broken.
    always_comb begin
        is_broken_d = is_broken_q | set_broken_i;
        cnt_d       = cnt_q;
        for (int k = 0; k < N_REP; k++) begin
            if (!is_broken_q[k]) begin
                if (mismatch[k]) begin
                    if (32'(cnt_q[k]) + 32'd1 >= ERR_THRESH) begin
                        is_broken_d[k] = 1'b1;
                        cnt_d[k]       = CNT_W'(ERR_THRESH);
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end else if (cnt_q[k] != '0) begin
                    cnt_d[k] = cnt_q[k] - 1'b1;
                end
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_mismatch;
    assign unused_mismatch = ^mismatch;

    // Without counters only the explicit request breaks a replica.
    always_comb begin
        is_broken_d = is_broken_q | set_broken_i;
    end
`endif

    // Sticky broken flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) is_broken_q <= '0;
        else        is_broken_q <= is_broken_d;
    end

    assign is_broken_o = is_broken_q;

endmodule

// File: tb/tb_cv32e40p_compressed_dec_ft.sv
// Bench for the TMR RVC decompressor: directed fault scenarios followed by a
// randomized run, checked against a lane-level voting/health model driven by
// a table of hand-decoded RVC encodings.
module tb_cv32e40p_compressed_dec_ft;

    localparam int NT     = 11;
    localparam int THRESH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0][31:0] instr_i;
    logic [2:0][31:0] instr_o;
    logic [2:0]       is_compressed_o;
    logic [2:0]       illegal_instr_o;
    logic [2:0]       set_broken_i;
    logic [2:0]       is_broken_o;

    cv32e40p_compressed_dec_ft dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_i         (instr_i),
        .instr_o         (instr_o),
        .is_compressed_o (is_compressed_o),
        .illegal_instr_o (illegal_instr_o),
        .set_broken_i    (set_broken_i),
        .is_broken_o     (is_broken_o)
    );

    always #5 clk = ~clk;

    // Encodings with their RV32 expansion, worked out by hand from the ISA.
    logic [31:0] t_in  [NT] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0013, 32'h0000_4505,
                                32'h0000_852E, 32'h0000_8082, 32'h0000_9002, 32'h0000_4080,
                                32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_6101};
    logic [31:0] t_out [NT] = '{32'h0001_0413, 32'h0000_0013, 32'h0000_0013, 32'h0010_0513,
                                32'h00B0_0533, 32'h0000_8067, 32'h0010_0073, 32'h0004_A403,
                                32'h0000_0000, 32'hDEAD_BEEF, 32'h0001_0113};
    logic        t_cmp [NT] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1};
    logic        t_ill [NT] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [33:0] lane_b [3];
    logic [33:0] exp_v;
    bit          mm_m  [3];
    bit          brk_m [3];
    int          cnt_m [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin brk_m[k] = 0; cnt_m[k] = 0; end
    endfunction

    // Expected vote from the lane results and the model's health state.
    function automatic void model_eval();
        int hl[$];
        bit disagree = 0;
        for (int k = 0; k < 3; k++) if (!brk_m[k]) hl.push_back(k);
        case (hl.size())
            3: for (int b = 0; b < 34; b++)
                   exp_v[b] = (int'(lane_b[0][b]) + int'(lane_b[1][b]) + int'(lane_b[2][b])) >= 2;
            2: begin exp_v = lane_b[hl[0]]; disagree = (lane_b[hl[0]] != lane_b[hl[1]]); end
            1: exp_v = lane_b[hl[0]];
            default: exp_v = lane_b[0];
        endcase
        for (int k = 0; k < 3; k++) mm_m[k] = !brk_m[k] && ((lane_b[k] != exp_v) || disagree);
    endfunction

    // Health bookkeeping for one clock edge.
    function automatic void model_edge(input logic [2:0] sb);
        bit nb [3];
        for (int k = 0; k < 3; k++) begin
            nb[k] = brk_m[k] || sb[k];
`ifdef CV32E40P_FT_AUTO_BROKEN_EN
            if (!brk_m[k]) begin
                if (mm_m[k]) begin
                    if (cnt_m[k] + 1 >= THRESH) nb[k] = 1;
                    cnt_m[k] = (cnt_m[k] + 1 > THRESH) ? THRESH : cnt_m[k] + 1;
                end else if (cnt_m[k] > 0) begin
                    cnt_m[k]--;
                end
            end
`endif
        end
        for (int k = 0; k < 3; k++) brk_m[k] = nb[k];
    endfunction

    function automatic logic [2:0] brk_vec();
        return {brk_m[2], brk_m[1], brk_m[0]};
    endfunction

    task automatic drive(input int i0, input int i1, input int i2);
        int idx [3];
        idx = '{i0, i1, i2};
        for (int k = 0; k < 3; k++) begin
            instr_i[k] = t_in[idx[k]];
            lane_b[k]  = {t_ill[idx[k]], t_cmp[idx[k]], t_out[idx[k]]};
        end
    endtask

    task automatic check_outputs(input string tag);
        model_eval();
        for (int k = 0; k < 3; k++) chk({tag, " instr"}, 64'(instr_o[k]), 64'(exp_v[31:0]));
        chk({tag, " is_compressed"}, 64'(is_compressed_o), 64'({3{exp_v[32]}}));
        chk({tag, " illegal"}, 64'(illegal_instr_o), 64'({3{exp_v[33]}}));
    endtask

    // One clock: drive after negedge, check comb outputs, then the flags after posedge.
    task automatic step(input string tag, input int i0, input int i1, input int i2, input logic [2:0] sb);
        drive(i0, i1, i2);
        set_broken_i = sb;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge(sb);
        #1;
        chk({tag, " is_broken"}, 64'(is_broken_o), 64'(brk_vec()));
        @(negedge clk);
        set_broken_i = '0;
    endtask

    task automatic mid_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, " is_broken"}, 64'(is_broken_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        set_broken_i = '0;
        model_reset();
        drive(0, 0, 0);
        #1;
        check_outputs("reset_zero");
        chk("reset_zero const instr", 64'(instr_o[0]), 64'h0001_0413);
        chk("reset is_broken", 64'(is_broken_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("addi_passthru", 2, 2, 2, 3'b000);
        chk("addi_passthru const", 64'(instr_o[1]), 64'h0000_0013);

        // Short lane-2 upset, then a long quiet period: counter leaks back.
        for (int c = 0; c < 2; c++)  step("lane2_glitch", 0, 0, 1, 3'b000);
        for (int c = 0; c < 30; c++) step("leak", 0, 0, 0, 3'b000);
        chk("after_leak is_broken", 64'(is_broken_o), 64'd0);

        // Persistent lane-2 fault.
        for (int c = 0; c < 8; c++) step("lane2_persist", 0, 0, 1, 3'b000);
        chk("lane2_persist instr", 64'(instr_o[2]), 64'h0001_0413);
`ifdef CV32E40P_FT_AUTO_BROKEN_EN
        chk("lane2_persist auto broken", 64'(is_broken_o), 64'b100);
`else
        chk("lane2_persist no auto", 64'(is_broken_o), 64'b000);
`endif
        mid_reset("reset_while_broken");

        // Lane 0 forced out; lanes 1/2 disagree, lane 1 wins.
        step("force_lane0", 1, 0, 0, 3'b001);
        for (int c = 0; c < 3; c++) step("split_1_2", 1, 0, 1, 3'b000);
        chk("split_1_2 winner", 64'(instr_o[0]), 64'h0001_0413);
        step("split_2_1", 0, 1, 0, 3'b000);
        chk("split_2_1 winner", 64'(instr_o[2]), 64'h0000_0013);
        step("force_lane1", 0, 0, 1, 3'b010);
        step("only_lane2", 0, 0, 1, 3'b000);
        chk("only_lane2 c.nop", 64'(instr_o[0]), 64'h0000_0013);
        step("all_broken", 3, 4, 5, 3'b100);
        step("all_broken_b0", 3, 4, 5, 3'b000);
        mid_reset("reset_mid_op");
        step("after_reset_vote", 3, 4, 4, 3'b000);

        // Randomized: mostly agreeing lanes with injected single/multi-lane faults.
        for (int n = 0; n < 600; n++) begin
            int base, idx [3];
            logic [2:0] sb;
            base = int'($urandom_range(0, NT - 1));
            idx  = '{base, base, base};
            if ($urandom_range(0, 2) == 0) idx[$urandom_range(0, 2)] = int'($urandom_range(0, NT - 1));
            if ($urandom_range(0, 9) == 0) idx[$urandom_range(0, 2)] = int'($urandom_range(0, NT - 1));
            sb = ($urandom_range(0, 39) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            step("random", idx[0], idx[1], idx[2], sb);
            if (n % 150 == 149) mid_reset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
